axi_mst_wr_gen: RTL and testbench

- Parametrised AXI3 write-master traffic generator for the crossbar testbench.
- Accepts burst commands, issues AW, and tracks outstanding bursts in an in-order W FIFO.
- Drives W beats with LFSR data and narrow-transfer strobes, and checks B responses against a per-ID outstanding table.
- Sits between test sequences and one crossbar slave port; one instance per master.

---
 rtl/axi_mst_wr_gen.sv | 242 ++++++++++++++++++++++++
 tb/tb_axi_mst_wr_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mst_wr_gen.sv
// AXI3 write-master traffic generator: accepts burst commands, issues AW,
// streams LFSR-data W beats with narrow strobes in AW order, and checks B
// responses against a per-ID outstanding table.
// Optional macro AXI_MST_BREADY_BP_EN: pseudo-random backpressure on out_bready.
module axi_mst_wr_gen #(
    parameter int unsigned AXI_ADDR_W      = 32,
    parameter int unsigned AXI_ID_W        = 4,
    parameter int unsigned AXI_DATA_W      = 32,
    parameter int unsigned MST_OSTDREQ_NUM = 4,
    parameter int unsigned CNT_W           = 16,
    parameter logic [31:0] LFSR_SEED       = 32'hACE12468
) (
    input  logic                                aclk,
    input  logic                                srst,
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic [AXI_ADDR_W-1:0]               cmd_addr,
    input  logic [3:0]                          cmd_len,
    input  logic [2:0]                          cmd_size,
    input  logic [1:0]                          cmd_burst,
    input  logic [AXI_ID_W-1:0]                 cmd_id,
    output logic                                out_awvalid,
    input  logic                                in_awready,
    output logic [AXI_ADDR_W-1:0]               out_awaddr,
    output logic [3:0]                          out_awlen,
    output logic [2:0]                          out_awsize,
    output logic [1:0]                          out_awburst,
    output logic [AXI_ID_W-1:0]                 out_awid,
    output logic [1:0]                          out_awlock,
    output logic                                out_wvalid,
    input  logic                                in_wready,
    output logic [AXI_ID_W-1:0]                 out_wid,
    output logic [AXI_DATA_W-1:0]               out_wdata,
    output logic [AXI_DATA_W/8-1:0]             out_wstrb,
    output logic                                out_wlast,
    input  logic                                in_bvalid,
    output logic                                out_bready,
    input  logic [AXI_ID_W-1:0]                 in_bid,
    input  logic [1:0]                          in_bresp,
    output logic [$clog2(MST_OSTDREQ_NUM):0]    ostd_cnt,
    output logic [CNT_W-1:0]                    bresp_err_cnt,
    output logic [CNT_W-1:0]                    bid_err_cnt,
    output logic [CNT_W-1:0]                    done_cnt
);

    localparam int unsigned STRB_W = AXI_DATA_W / 8;
    localparam int unsigned LB     = $clog2(STRB_W);
    localparam int unsigned LB_W   = (LB > 0) ? LB : 1;
    localparam int unsigned PTR_W  = $clog2(MST_OSTDREQ_NUM);
    localparam int unsigned OST_W  = PTR_W + 1;
    localparam int unsigned ID_N   = 2 ** AXI_ID_W;

    typedef struct packed {
        logic [3:0]          len;
        logic [AXI_ID_W-1:0] id;
        logic [2:0]          size;
        logic [1:0]          burst;
        logic [LB_W-1:0]     lo;
    } wcmd_t;

    wcmd_t              fifo_q [MST_OSTDREQ_NUM];
    wcmd_t              aw_entry;
    wcmd_t              head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OST_W-1:0]   fifo_cnt;
    logic [3:0]         beat_cnt;
    logic [31:0]        lfsr_q;
    logic [OST_W-1:0]   id_tab [ID_N];
    logic [OST_W-1:0]   ostd_nxt;

    logic cmd_hs, aw_hs, w_valid, w_hs, w_pop, b_hs, b_hit, b_dec;
    logic [31:0] size_bytes;
    logic [31:0] lane;

    assign out_awlock = 2'b00;
    assign cmd_ready  = !out_awvalid && (ostd_cnt < OST_W'(MST_OSTDREQ_NUM));
    assign cmd_hs     = cmd_valid && cmd_ready;
    assign aw_hs      = out_awvalid && in_awready;
    assign head       = fifo_q[rd_ptr];
    assign w_valid    = (fifo_cnt != '0);
    assign w_hs       = w_valid && in_wready;
    assign w_pop      = w_hs && (beat_cnt == head.len);
    assign b_hs       = in_bvalid && out_bready;
    assign b_hit      = (id_tab[in_bid] != '0);
    assign b_dec      = b_hs && b_hit;

    assign aw_entry = '{len: out_awlen, id: out_awid, size: out_awsize,
                        burst: out_awburst, lo: out_awaddr[LB_W-1:0]};

    assign out_wvalid = w_valid;
    assign out_wid    = w_valid ? head.id : '0;
    assign out_wlast  = w_valid && (beat_cnt == head.len);

    // Outstanding-burst count after this cycle's AW and B handshakes
    always_comb begin
        ostd_nxt = ostd_cnt;
        if (aw_hs && !b_dec)
            ostd_nxt = ostd_cnt + 1'b1;
        else if (!aw_hs && b_dec)
            ostd_nxt = ostd_cnt - 1'b1;
    end

    // First byte lane of the current beat; WRAP follows the INCR lane rule
    always_comb begin
        size_bytes = 32'd1 << head.size;
        lane       = 32'(head.lo) & ~(size_bytes - 32'd1);
        if (head.burst != 2'b00)
            lane = lane + (32'(beat_cnt) << head.size);
        lane = lane & 32'(STRB_W - 1);
    end

    for (genvar g = 0; g < STRB_W; g++) begin : g_strb
        assign out_wstrb[g] = w_valid && (32'(g) >= lane) && (32'(g) < lane + size_bytes);
    end

    for (genvar g = 0; g < AXI_DATA_W; g++) begin : g_wdata
        assign out_wdata[g] = w_valid && lfsr_q[g % 32];
    end

    // AW channel registers: load on command accept, hold until awready
    always_ff @(posedge aclk) begin
        if (srst) begin
            out_awvalid <= 1'b0;
            out_awaddr  <= '0;
            out_awlen   <= '0;
            out_awsize  <= '0;
            out_awburst <= '0;
            out_awid    <= '0;
        end else if (cmd_hs) begin
            out_awvalid <= 1'b1;
            out_awaddr  <= cmd_addr;
            out_awlen   <= cmd_len;
            out_awsize  <= cmd_size;
            out_awburst <= cmd_burst;
            out_awid    <= cmd_id;
        end else if (aw_hs) begin
            out_awvalid <= 1'b0;
        end
    end

    // In-order W FIFO storage, one register per slot
    for (genvar g = 0; g < MST_OSTDREQ_NUM; g++) begin : g_fifo
        wcmd_t slot_q;
        always_ff @(posedge aclk) begin
            if (srst)
                slot_q <= '0;
            else if (aw_hs && (wr_ptr == PTR_W'(g)))
                slot_q <= aw_entry;
        end
        assign fifo_q[g] = slot_q;
    end

    // FIFO pointers, occupancy and beat counter
    always_ff @(posedge aclk) begin
        if (srst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            beat_cnt <= '0;
        end else begin
            if (aw_hs)
                wr_ptr <= wr_ptr + 1'b1;
            if (w_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (aw_hs && !w_pop)
                fifo_cnt <= fifo_cnt + 1'b1;
            else if (!aw_hs && w_pop)
                fifo_cnt <= fifo_cnt - 1'b1;
            if (w_hs)
                beat_cnt <= w_pop ? 4'd0 : beat_cnt + 4'd1;
        end
    end

    // W data LFSR (taps 32,22,2,1), steps only on a W handshake
    always_ff @(posedge aclk) begin
        if (srst)
            lfsr_q <= LFSR_SEED;
        else if (w_hs)
            lfsr_q <= {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
    end

    // Per-ID outstanding table; same-cycle AW and B on one ID cancel
    for (genvar g = 0; g < ID_N; g++) begin : g_idtab
        logic [OST_W-1:0] ent_q;
        logic inc, dec;
        assign inc = aw_hs && (out_awid == AXI_ID_W'(g));
        assign dec = b_dec && (in_bid == AXI_ID_W'(g));
        always_ff @(posedge aclk) begin
            if (srst)
                ent_q <= '0;
            else if (inc && !dec)
                ent_q <= ent_q + 1'b1;
            else if (!inc && dec)
                ent_q <= ent_q - 1'b1;
        end
        assign id_tab[g] = ent_q;
    end

    // Outstanding count and saturating completion/error counters
    always_ff @(posedge aclk) begin
        if (srst) begin
            ostd_cnt      <= '0;
            done_cnt      <= '0;
            bid_err_cnt   <= '0;
            bresp_err_cnt <= '0;
        end else begin
            ostd_cnt <= ostd_nxt;
            if (b_hs) begin
                if (b_hit) begin
                    if (done_cnt != '1)
                        done_cnt <= done_cnt + 1'b1;
                end else if (bid_err_cnt != '1) begin
                    bid_err_cnt <= bid_err_cnt + 1'b1;
                end
                if ((in_bresp != 2'b00) && (bresp_err_cnt != '1))
                    bresp_err_cnt <= bresp_err_cnt + 1'b1;
            end
        end
    end

`ifdef AXI_MST_BREADY_BP_EN
    logic [15:0] bp_lfsr_q;
    logic        bready_q;

    // Pseudo-random B backpressure from a free-running 16-bit LFSR
    always_ff @(posedge aclk) begin
        if (srst) begin
            bp_lfsr_q <= 16'hB00B;
            bready_q  <= 1'b0;
        end else begin
            bp_lfsr_q <= {bp_lfsr_q[14:0],
                          bp_lfsr_q[15] ^ bp_lfsr_q[13] ^ bp_lfsr_q[12] ^ bp_lfsr_q[10]};
            bready_q  <= (ostd_nxt != '0) && bp_lfsr_q[0];
        end
    end
    assign out_bready = bready_q;
`else
    assign out_bready = (ostd_cnt != '0);
`endif

endmodule

// File: tb/tb_axi_mst_wr_gen.sv
// Directed testbench for axi_mst_wr_gen with default parameters.
module tb_axi_mst_wr_gen;

    logic        aclk;
    logic        srst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic [3:0]  cmd_id;
    logic        out_awvalid;
    logic        in_awready;
    logic [31:0] out_awaddr;
    logic [3:0]  out_awlen;
    logic [2:0]  out_awsize;
    logic [1:0]  out_awburst;
    logic [3:0]  out_awid;
    logic [1:0]  out_awlock;
    logic        out_wvalid;
    logic        in_wready;
    logic [3:0]  out_wid;
    logic [31:0] out_wdata;
    logic [3:0]  out_wstrb;
    logic        out_wlast;
    logic        in_bvalid;
    logic        out_bready;
    logic [3:0]  in_bid;
    logic [1:0]  in_bresp;
    logic [2:0]  ostd_cnt;
    logic [15:0] bresp_err_cnt;
    logic [15:0] bid_err_cnt;
    logic [15:0] done_cnt;

    int          vecs = 0;
    int          errs = 0;
    logic [31:0] m_lfsr;

    axi_mst_wr_gen dut (
        .aclk(aclk), .srst(srst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_id(cmd_id),
        .out_awvalid(out_awvalid), .in_awready(in_awready), .out_awaddr(out_awaddr),
        .out_awlen(out_awlen), .out_awsize(out_awsize), .out_awburst(out_awburst),
        .out_awid(out_awid), .out_awlock(out_awlock),
        .out_wvalid(out_wvalid), .in_wready(in_wready), .out_wid(out_wid),
        .out_wdata(out_wdata), .out_wstrb(out_wstrb), .out_wlast(out_wlast),
        .in_bvalid(in_bvalid), .out_bready(out_bready), .in_bid(in_bid), .in_bresp(in_bresp),
        .ostd_cnt(ostd_cnt), .bresp_err_cnt(bresp_err_cnt),
        .bid_err_cnt(bid_err_cnt), .done_cnt(done_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic fb;
        fb = s[31] ^ s[21] ^ s[1] ^ s[0];
        return {s[30:0], fb};
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s,
                            input logic [1:0] b, input logic [3:0] id);
        int n;
        cmd_addr = a; cmd_len = l; cmd_size = s; cmd_burst = b; cmd_id = id;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        chk("cmd_ready_wait", 64'(cmd_ready), 64'h1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic chk_w(input string tag, input logic [3:0] strb, input logic last,
                         input logic [3:0] id);
        chk({tag, "_wvalid"}, 64'(out_wvalid), 64'h1);
        chk({tag, "_wdata"},  64'(out_wdata),  64'(m_lfsr));
        chk({tag, "_wstrb"},  64'(out_wstrb),  64'(strb));
        chk({tag, "_wlast"},  64'(out_wlast),  64'(last));
        chk({tag, "_wid"},    64'(out_wid),    64'(id));
    endtask

    task automatic w_beat(input string tag, input logic [3:0] strb, input logic last,
                          input logic [3:0] id);
        in_wready = 1'b1;
        chk_w(tag, strb, last, id);
        tick();
        in_wready = 1'b0;
        m_lfsr = lfsr_step(m_lfsr);
    endtask

    task automatic b_resp(input logic [3:0] id, input logic [1:0] resp);
        in_bid = id; in_bresp = resp; in_bvalid = 1'b1;
        tick();
        in_bvalid = 1'b0; in_bid = 4'd0; in_bresp = 2'b00;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_awvalid"}, 64'(out_awvalid), 64'h0);
        chk({tag, "_wvalid"},  64'(out_wvalid),  64'h0);
        chk({tag, "_wdata"},   64'(out_wdata),   64'h0);
        chk({tag, "_wstrb"},   64'(out_wstrb),   64'h0);
        chk({tag, "_wlast"},   64'(out_wlast),   64'h0);
        chk({tag, "_wid"},     64'(out_wid),     64'h0);
        chk({tag, "_bready"},  64'(out_bready),  64'h0);
        chk({tag, "_ostd"},    64'(ostd_cnt),    64'h0);
        chk({tag, "_done"},    64'(done_cnt),    64'h0);
        chk({tag, "_biderr"},  64'(bid_err_cnt), 64'h0);
        chk({tag, "_resperr"}, 64'(bresp_err_cnt), 64'h0);
        chk({tag, "_cmdrdy"},  64'(cmd_ready),   64'h1);
    endtask

    initial begin
        srst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
        cmd_burst = '0; cmd_id = '0; in_awready = 1'b1; in_wready = 1'b0;
        in_bvalid = 1'b0; in_bid = '0; in_bresp = '0;
        m_lfsr = 32'hACE12468;
        tick();
        tick();
        srst = 1'b0;
        chk_idle("reset");

        // Single INCR burst, 4 beats of full-width data
        send_cmd(32'h100, 4'd3, 3'd2, 2'b01, 4'd5);
        chk("aw_valid", 64'(out_awvalid), 64'h1);
        chk("aw_addr",  64'(out_awaddr),  64'h100);
        chk("aw_len",   64'(out_awlen),   64'h3);
        chk("aw_size",  64'(out_awsize),  64'h2);
        chk("aw_burst", 64'(out_awburst), 64'h1);
        chk("aw_id",    64'(out_awid),    64'h5);
        chk("aw_lock",  64'(out_awlock),  64'h0);
        chk("aw_cmdrdy", 64'(cmd_ready),  64'h0);
        tick();
        chk("aw_clr",  64'(out_awvalid), 64'h0);
        chk("t1_ostd", 64'(ostd_cnt),    64'h1);
        chk("t1_brdy", 64'(out_bready),  64'h1);
        w_beat("t1b0", 4'hF, 1'b0, 4'd5);
        w_beat("t1b1", 4'hF, 1'b0, 4'd5);
        w_beat("t1b2", 4'hF, 1'b0, 4'd5);
        w_beat("t1b3", 4'hF, 1'b1, 4'd5);
        chk("t1_wvalid_end", 64'(out_wvalid), 64'h0);
        chk("t1_wstrb_end",  64'(out_wstrb),  64'h0);
        b_resp(4'd5, 2'b00);
        chk("t1_done",  64'(done_cnt),   64'h1);
        chk("t1_ostd0", 64'(ostd_cnt),   64'h0);
        chk("t1_brdy0", 64'(out_bready), 64'h0);

        // Narrow FIXED, narrow INCR, and halfword INCR lane wrap
        send_cmd(32'h3, 4'd1, 3'd0, 2'b00, 4'd2);
        tick();
        w_beat("fix_b0", 4'h8, 1'b0, 4'd2);
        w_beat("fix_b1", 4'h8, 1'b1, 4'd2);
        b_resp(4'd2, 2'b00);
        send_cmd(32'h3, 4'd1, 3'd0, 2'b01, 4'd2);
        tick();
        w_beat("inc_b0", 4'h8, 1'b0, 4'd2);
        w_beat("inc_b1", 4'h1, 1'b1, 4'd2);
        b_resp(4'd2, 2'b00);
        send_cmd(32'h2, 4'd2, 3'd1, 2'b01, 4'd3);
        tick();
        w_beat("hw_b0", 4'hC, 1'b0, 4'd3);
        w_beat("hw_b1", 4'h3, 1'b0, 4'd3);
        w_beat("hw_b2", 4'hC, 1'b1, 4'd3);
        b_resp(4'd3, 2'b00);
        chk("t2_done", 64'(done_cnt), 64'h4);

        // Outstanding limit: four bursts pending, fifth command stalls
        send_cmd(32'h0, 4'd0, 3'd2, 2'b01, 4'd1); tick();
        send_cmd(32'h0, 4'd0, 3'd2, 2'b01, 4'd1); tick();
        send_cmd(32'h0, 4'd0, 3'd2, 2'b01, 4'd6); tick();
        send_cmd(32'h0, 4'd0, 3'd2, 2'b01, 4'd7); tick();
        chk("lim_ostd4",  64'(ostd_cnt),  64'h4);
        chk("lim_cmdrdy", 64'(cmd_ready), 64'h0);
        cmd_addr = 32'h0; cmd_len = 4'd0; cmd_size = 3'd2; cmd_burst = 2'b01; cmd_id = 4'd8;
        cmd_valid = 1'b1;
        tick();
        tick();
        chk("lim_stall_aw", 64'(out_awvalid), 64'h0);
        chk("lim_stall_rdy", 64'(cmd_ready),  64'h0);
        w_beat("lim_w0", 4'hF, 1'b1, 4'd1);
        w_beat("lim_w1", 4'hF, 1'b1, 4'd1);
        w_beat("lim_w2", 4'hF, 1'b1, 4'd6);
        w_beat("lim_w3", 4'hF, 1'b1, 4'd7);
        chk("lim_ostd_wdone", 64'(ostd_cnt), 64'h4);
        b_resp(4'd1, 2'b00);
        chk("lim_rdy_back", 64'(cmd_ready), 64'h1);
        chk("lim_ostd3",    64'(ostd_cnt),  64'h3);
        tick();
        cmd_valid = 1'b0;
        chk("lim_aw5_valid", 64'(out_awvalid), 64'h1);
        chk("lim_aw5_id",    64'(out_awid),    64'h8);
        tick();
        chk("lim_ostd4b", 64'(ostd_cnt), 64'h4);
        w_beat("lim_w4", 4'hF, 1'b1, 4'd8);
        b_resp(4'd1, 2'b00);
        b_resp(4'd6, 2'b00);
        b_resp(4'd7, 2'b00);
        b_resp(4'd8, 2'b00);
        chk("lim_ostd0",  64'(ostd_cnt),    64'h0);
        chk("lim_done",   64'(done_cnt),    64'h9);
        chk("lim_biderr", 64'(bid_err_cnt), 64'h0);

        // W backpressure: wready 1,0,0,1 holds payload, LFSR steps twice
        send_cmd(32'h0, 4'd1, 3'd2, 2'b01, 4'd4);
        tick();
        w_beat("bp_b0", 4'hF, 1'b0, 4'd4);
        chk_w("bp_hold0", 4'hF, 1'b1, 4'd4);
        tick();
        chk_w("bp_hold1", 4'hF, 1'b1, 4'd4);
        tick();
        w_beat("bp_b1", 4'hF, 1'b1, 4'd4);
        chk("bp_wvalid_end", 64'(out_wvalid), 64'h0);
        b_resp(4'd4, 2'b00);

        // Error responses: unknown ID and SLVERR
        send_cmd(32'h0, 4'd0, 3'd2, 2'b01, 4'd3);
        tick();
        w_beat("err_w", 4'hF, 1'b1, 4'd3);
        b_resp(4'd9, 2'b00);
        chk("err_biderr", 64'(bid_err_cnt), 64'h1);
        chk("err_ostd1",  64'(ostd_cnt),    64'h1);
        chk("err_done10", 64'(done_cnt),    64'hA);
        b_resp(4'd3, 2'b10);
        chk("err_resperr", 64'(bresp_err_cnt), 64'h1);
        chk("err_done11",  64'(done_cnt),      64'hB);
        chk("err_ostd0",   64'(ostd_cnt),      64'h0);
        chk("err_biderr1", 64'(bid_err_cnt),   64'h1);

        // Reset in the middle of a 8-beat burst
        send_cmd(32'h0, 4'd7, 3'd2, 2'b01, 4'd2);
        tick();
        w_beat("rst_b0", 4'hF, 1'b0, 4'd2);
        w_beat("rst_b1", 4'hF, 1'b0, 4'd2);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        chk_idle("midrst");
        m_lfsr = 32'hACE12468;
        send_cmd(32'h20, 4'd0, 3'd2, 2'b01, 4'd1);
        tick();
        chk("restart_wdata", 64'(out_wdata), 64'hACE12468);
        w_beat("restart_b0", 4'hF, 1'b1, 4'd1);
        b_resp(4'd1, 2'b00);
        chk("restart_done", 64'(done_cnt), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
